// File: rtl/axis_dsrc_pkg.sv
// Shared definitions for the AXIS pattern source and sink/checker blocks.
// Command codes, data types, status bit positions and state encoding.
package axis_dsrc_pkg;

    localparam logic [31:0] CMD_START = 32'd1;
    localparam logic [31:0] CMD_RESET = 32'd2;
    localparam logic [31:0] CMD_STOP  = 32'd3;
    localparam logic [31:0] DTYPE_DEC = 32'd1;

    localparam int STAT_EN   = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_DERR = 2;
    localparam int STAT_LERR = 3;
    localparam int STAT_OVR  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_dpat_gen.sv
// Expected-pattern register: steps by +/-1, optionally from a loaded base.
// Shared between the pattern source and the sink/checker.
module axis_dpat_gen
    import axis_dsrc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         step,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] base;

    assign base = load ? load_val : value;

    // Advance the pattern from the current value or the loaded base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (step) begin
            value <= dec ? base - ONE : base + ONE;
        end
    end

endmodule

// File: rtl/axis_dsnk_chk.sv
// AXI4-Stream sink that checks data against an inc/dec pattern and TLAST placement.
// Optional TREADY throttling via a 16-bit LFSR when AXIS_DSNK_THROTTLE_EN is defined.
module axis_dsnk_chk
    import axis_dsrc_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_NUM_BYTES = 4,
    parameter int C_RESYNC_ON_ERR          = 1
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESET,
    input  logic                                  S_AXIS_TVALID,
    input  logic [8*C_S_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
    input  logic                                  S_AXIS_TLAST,
    output logic                                  S_AXIS_TREADY,
    input  logic [31:0]                           cmd,
    input  logic [31:0]                           num_bytes,
    input  logic [31:0]                           data_type,
    input  logic [31:0]                           num_pkts,
    input  logic                                  new_cmd,
    output logic [31:0]                           stat,
    output logic [31:0]                           rx_cnt,
    output logic [31:0]                           rx_pkt_cnt,
    output logic [31:0]                           err_cnt,
    output logic [31:0]                           tlast_err_cnt,
    output logic [31:0]                           first_err_data
);

    localparam int          NB   = C_S_AXIS_TDATA_NUM_BYTES;
    localparam int          W    = 8 * NB;
    localparam logic [32:0] NB33 = 33'(NB);

    state_t       state;
    logic         rx_enable;
    logic         rx_done;
    logic         data_err;
    logic         tlast_err;
    logic         ovr;
    logic         missed;
    logic         tready_q;
    logic [W-1:0] exp_val;

    logic         accept;
    logic         match;
    logic         derr;
    logic         close_done;
    logic         idle_done;
    logic         cmd_start;
    logic         cmd_reset;
    logic         cmd_stop;
    logic         en_n;
    logic         done_n;
    logic [32:0]  cnt_sum;
    logic [31:0]  err_word;

    assign accept = S_AXIS_TVALID & S_AXIS_TREADY;
    assign stat   = {27'h0, ovr, tlast_err, data_err, rx_done, rx_enable};

    // Beat classification and next values of the enable/done flags.
    always_comb begin
        match      = (S_AXIS_TDATA == exp_val);
        derr       = !match || !(&S_AXIS_TSTRB);
        err_word   = 32'(S_AXIS_TDATA);
        cnt_sum    = {1'b0, rx_cnt} + NB33;
        close_done = accept && S_AXIS_TLAST &&
                     (({1'b0, rx_pkt_cnt} + 33'd1) >= {1'b0, num_pkts});
        idle_done  = (state == IDLE) && rx_enable && !rx_done &&
                     (num_pkts == 32'd0);
        cmd_start  = new_cmd && (cmd == CMD_START);
        cmd_reset  = new_cmd && (cmd == CMD_RESET);
        cmd_stop   = new_cmd && (cmd == CMD_STOP);
        en_n       = rx_enable;
        if (close_done || idle_done) en_n = 1'b0;
        if (cmd_start) en_n = 1'b1;
        if (cmd_stop || cmd_reset) en_n = 1'b0;
        done_n     = !cmd_reset && (rx_done || close_done || idle_done);
    end

    axis_dpat_gen #(
        .W(W)
    ) u_pat (
        .clk      (AXIS_ACLK),
        .rst      (AXIS_ARESET),
        .clr      (cmd_reset),
        .step     (accept),
        .dec      (data_type == DTYPE_DEC),
        .load     ((C_RESYNC_ON_ERR != 0) && !match),
        .load_val (S_AXIS_TDATA),
        .value    (exp_val)
    );

    // Receive FSM, counters, sticky status and registered TREADY.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state          <= IDLE;
            rx_enable      <= 1'b0;
            rx_done        <= 1'b0;
            data_err       <= 1'b0;
            tlast_err      <= 1'b0;
            ovr            <= 1'b0;
            missed         <= 1'b0;
            tready_q       <= 1'b0;
            rx_cnt         <= '0;
            rx_pkt_cnt     <= '0;
            err_cnt        <= '0;
            tlast_err_cnt  <= '0;
            first_err_data <= '0;
        end else if (cmd_reset) begin
            state          <= IDLE;
            rx_enable      <= 1'b0;
            rx_done        <= 1'b0;
            data_err       <= 1'b0;
            tlast_err      <= 1'b0;
            ovr            <= 1'b0;
            missed         <= 1'b0;
            tready_q       <= 1'b0;
            rx_cnt         <= '0;
            rx_pkt_cnt     <= '0;
            err_cnt        <= '0;
            tlast_err_cnt  <= '0;
            first_err_data <= '0;
        end else begin
            rx_enable <= en_n;
            rx_done   <= done_n;
            tready_q  <= en_n && !done_n && (num_pkts != 32'd0);
            case (state)
                IDLE: begin
                    if (done_n) state <= DONE;
                    else if (rx_enable) state <= RECV;
                end
                RECV: begin
                    if (done_n) state <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
            if (accept) begin
                if (derr) begin
                    err_cnt  <= sat_inc(err_cnt);
                    data_err <= 1'b1;
                    if (err_cnt == 32'd0) first_err_data <= err_word;
                end
                if (S_AXIS_TLAST) begin
                    if ((cnt_sum < {1'b0, num_bytes}) && !missed) begin
                        tlast_err_cnt <= sat_inc(tlast_err_cnt);
                        tlast_err     <= 1'b1;
                    end
                    rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
                    rx_cnt     <= '0;
                    missed     <= 1'b0;
                end else begin
                    rx_cnt <= cnt_sum[31:0];
                    if (cnt_sum[32]) ovr <= 1'b1;
                    if ((cnt_sum[31:0] == num_bytes) && !missed) begin
                        tlast_err_cnt <= sat_inc(tlast_err_cnt);
                        tlast_err     <= 1'b1;
                        missed        <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef AXIS_DSNK_THROTTLE_EN
    logic [15:0] lfsr;

    // Galois LFSR x^16+x^14+x^13+x^11+1 gating TREADY for backpressure.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            lfsr <= 16'hACE1;
        end else if (cmd_reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign S_AXIS_TREADY = tready_q & lfsr[0];
`else
    assign S_AXIS_TREADY = tready_q;
`endif

endmodule

// File: tb/tb_axis_dsnk_chk.sv
// Self-checking bench for axis_dsnk_chk: vector table, hand sequences,
// and randomized packets against a packet-level reference model.
module tb_axis_dsnk_chk;
    import axis_dsrc_pkg::*;

    localparam int NB     = 4;
    localparam int RESYNC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic [31:0] cmd;
    logic [31:0] num_bytes;
    logic [31:0] data_type;
    logic [31:0] num_pkts;
    logic        new_cmd;
    logic [31:0] stat;
    logic [31:0] rx_cnt;
    logic [31:0] rx_pkt_cnt;
    logic [31:0] err_cnt;
    logic [31:0] tlast_err_cnt;
    logic [31:0] first_err_data;

    always #5 clk = ~clk;

    axis_dsnk_chk #(
        .C_S_AXIS_TDATA_NUM_BYTES(NB),
        .C_RESYNC_ON_ERR(RESYNC)
    ) dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESET    (rst),
        .S_AXIS_TVALID  (tvalid),
        .S_AXIS_TDATA   (tdata),
        .S_AXIS_TSTRB   (tstrb),
        .S_AXIS_TLAST   (tlast),
        .S_AXIS_TREADY  (tready),
        .cmd            (cmd),
        .num_bytes      (num_bytes),
        .data_type      (data_type),
        .num_pkts       (num_pkts),
        .new_cmd        (new_cmd),
        .stat           (stat),
        .rx_cnt         (rx_cnt),
        .rx_pkt_cnt     (rx_pkt_cnt),
        .err_cnt        (err_cnt),
        .tlast_err_cnt  (tlast_err_cnt),
        .first_err_data (first_err_data)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state (packet-level view of the stream).
    logic [31:0] m_exp;
    logic [31:0] m_first;
    int          m_err;
    int          m_lerr;
    int          m_pkts;
    int          m_beats;
    int          m_nb;
    int          m_npkts;
    int          m_dtype;
    bit          m_derr;
    bit          m_lerr_f;

    typedef struct {
        int          dtype;
        int          nb;
        int          np;
        int          tmode;
        int          bad_idx;
        logic [31:0] bad_val;
        bit          jump;
        logic [3:0]  bad_strb;
        int          e_pkts;
        int          e_err;
        int          e_lerr;
        logic [31:0] e_first;
        logic [31:0] e_stat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_exp    = 32'h0;
        m_first  = 32'h0;
        m_err    = 0;
        m_lerr   = 0;
        m_pkts   = 0;
        m_beats  = 0;
        m_derr   = 1'b0;
        m_lerr_f = 1'b0;
    endtask

    task automatic model_beat(input logic [31:0] d, input logic [3:0] s,
                              input logic l);
        logic [31:0] base;
        if (d != m_exp || s != 4'hF) begin
            if (m_err == 0) m_first = d;
            m_err++;
            m_derr = 1'b1;
        end
        base  = (RESYNC != 0 && d != m_exp) ? d : m_exp;
        m_exp = (m_dtype == 1) ? base - 32'd1 : base + 32'd1;
        m_beats++;
        if (l) begin
            if (m_beats * NB != m_nb) begin
                m_lerr++;
                m_lerr_f = 1'b1;
            end
            m_pkts++;
            m_beats = 0;
        end
    endtask

    function automatic logic [31:0] m_stat();
        bit done;
        done = (m_pkts >= m_npkts);
        return {27'h0, 1'b0, m_lerr_f, m_derr, done, !done};
    endfunction

    task automatic send(input logic [31:0] d, input logic l,
                        input logic [3:0] s);
        bit acc;
        int n;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        tstrb  = s;
        acc    = 1'b0;
        n      = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = tready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept", 32'(acc), 32'h1);
        if (acc) model_beat(d, s, l);
    endtask

    task automatic do_cmd(input logic [31:0] c);
        cmd     = c;
        new_cmd = 1'b1;
        @(posedge clk);
        #1;
        new_cmd = 1'b0;
        if (c == CMD_RESET) model_reset();
    endtask

    task automatic setup(input int dt, input int nb, input int np);
        tvalid    = 1'b0;
        tlast     = 1'b0;
        data_type = 32'(dt);
        num_bytes = 32'(nb);
        num_pkts  = 32'(np);
        m_dtype   = dt;
        m_nb      = nb;
        m_npkts   = np;
        do_cmd(CMD_RESET);
        do_cmd(CMD_START);
    endtask

    initial begin
        logic [31:0] src;
        logic [31:0] d;
        logic [3:0]  s;
        int          gidx;
        int          k;
        bit          seen;

        rst       = 1'b1;
        tvalid    = 1'b0;
        tdata     = '0;
        tstrb     = 4'hF;
        tlast     = 1'b0;
        cmd       = '0;
        num_bytes = 32'd16;
        data_type = '0;
        num_pkts  = 32'd1;
        new_cmd   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(tready), 32'h0);
        chk("rst_stat", stat, 32'h0);
        chk("rst_rx_cnt", rx_cnt, 32'h0);
        chk("rst_pkt_cnt", rx_pkt_cnt, 32'h0);
        chk("rst_err_cnt", err_cnt, 32'h0);
        chk("rst_lerr_cnt", tlast_err_cnt, 32'h0);
        chk("rst_first_err", first_err_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // dtype nb np tmode bad_idx bad_val jump bad_strb | pkts err lerr first stat
        vecs[0] = '{0, 16, 3, 0, -1, 32'h0, 1'b0, 4'hF, 3, 0, 0, 32'h0, 32'h2};
        vecs[1] = '{1, 8, 2, 0, -1, 32'h0, 1'b0, 4'hF, 2, 0, 0, 32'h0, 32'h2};
        vecs[2] = '{0, 16, 3, 0, 5, 32'h55, 1'b1, 4'hF, 3, 1, 0, 32'h55, 32'h6};
        vecs[3] = '{0, 16, 3, 0, 5, 32'h55, 1'b0, 4'hF, 3, 2, 0, 32'h55, 32'h6};
        vecs[4] = '{0, 16, 2, 1, -1, 32'h0, 1'b0, 4'hF, 2, 0, 1, 32'h0, 32'hA};
        vecs[5] = '{0, 16, 2, 2, -1, 32'h0, 1'b0, 4'hF, 2, 0, 1, 32'h0, 32'hA};
        vecs[6] = '{0, 8, 1, 0, 1, 32'h0, 1'b0, 4'hE, 1, 1, 0, 32'h1, 32'h6};

        for (int i = 0; i < 7; i++) begin
            setup(vecs[i].dtype, vecs[i].nb, vecs[i].np);
            src  = 32'h0;
            gidx = 0;
            for (int p = 0; p < vecs[i].np; p++) begin
                k = vecs[i].nb / NB;
                if (p == 0 && vecs[i].tmode == 1) k = 2;
                if (p == 0 && vecs[i].tmode == 2) k = vecs[i].nb / NB + 1;
                for (int b = 0; b < k; b++) begin
                    d = src;
                    s = 4'hF;
                    if (gidx == vecs[i].bad_idx) begin
                        if (vecs[i].bad_strb != 4'hF) begin
                            s = vecs[i].bad_strb;
                        end else begin
                            d = vecs[i].bad_val;
                            if (vecs[i].jump) src = vecs[i].bad_val;
                        end
                    end
                    send(d, b == k - 1, s);
                    src = (vecs[i].dtype == 1) ? src - 32'd1 : src + 32'd1;
                    gidx++;
                end
            end
            tvalid = 1'b0;
            chk($sformatf("v%0d_tready", i), 32'(tready), 32'h0);
            chk($sformatf("v%0d_pkts", i), rx_pkt_cnt, 32'(vecs[i].e_pkts));
            chk($sformatf("v%0d_err", i), err_cnt, 32'(vecs[i].e_err));
            chk($sformatf("v%0d_lerr", i), tlast_err_cnt, 32'(vecs[i].e_lerr));
            chk($sformatf("v%0d_first", i), first_err_data, vecs[i].e_first);
            chk($sformatf("v%0d_stat", i), stat, vecs[i].e_stat);
        end

        // Stop mid-packet, hold, then resume.
        setup(0, 16, 1);
        send(32'd0, 1'b0, 4'hF);
        send(32'd1, 1'b0, 4'hF);
        tvalid = 1'b0;
        do_cmd(CMD_STOP);
        chk("stop_tready", 32'(tready), 32'h0);
        chk("stop_rx_cnt", rx_cnt, 32'd8);
        chk("stop_stat", stat, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rx_cnt", rx_cnt, 32'd8);
        chk("hold_tready", 32'(tready), 32'h0);
        do_cmd(CMD_START);
        send(32'd2, 1'b0, 4'hF);
        send(32'd3, 1'b1, 4'hF);
        tvalid = 1'b0;
        chk("resume_pkts", rx_pkt_cnt, 32'd1);
        chk("resume_err", err_cnt, 32'd0);
        chk("resume_lerr", tlast_err_cnt, 32'd0);
        chk("resume_stat", stat, 32'h2);
        chk("resume_rx_cnt", rx_cnt, 32'd0);

        // Synchronous reset command mid-packet.
        setup(0, 16, 2);
        send(32'd0, 1'b0, 4'hF);
        send(32'd7, 1'b0, 4'hF);
        tvalid = 1'b0;
        chk("pre_clr_err", err_cnt, 32'd1);
        do_cmd(CMD_RESET);
        chk("clr_rx_cnt", rx_cnt, 32'd0);
        chk("clr_err", err_cnt, 32'd0);
        chk("clr_first", first_err_data, 32'd0);
        chk("clr_stat", stat, 32'h0);
        chk("clr_tready", 32'(tready), 32'h0);
        chk("clr_pkts", rx_pkt_cnt, 32'd0);

        // Reset command in the same cycle as a TLAST beat: reset wins.
        setup(0, 8, 5);
        send(32'd0, 1'b0, 4'hF);
        tdata   = 32'd1;
        tlast   = 1'b1;
        cmd     = CMD_RESET;
        new_cmd = 1'b1;
        @(posedge clk);
        #1;
        new_cmd = 1'b0;
        tvalid  = 1'b0;
        model_reset();
        chk("rsttl_pkts", rx_pkt_cnt, 32'd0);
        chk("rsttl_rx_cnt", rx_cnt, 32'd0);
        chk("rsttl_tready", 32'(tready), 32'h0);

        // Stop in the same cycle as the closing beat: beat counted first.
        setup(0, 8, 3);
        send(32'd0, 1'b0, 4'hF);
        tvalid = 1'b0;
        seen   = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = tready;
        end
        chk("stopbeat_ready", 32'(seen), 32'h1);
        tvalid  = 1'b1;
        tdata   = 32'd1;
        tlast   = 1'b1;
        cmd     = CMD_STOP;
        new_cmd = 1'b1;
        @(posedge clk);
        #1;
        new_cmd = 1'b0;
        tvalid  = 1'b0;
        chk("stopbeat_pkts", rx_pkt_cnt, 32'd1);
        chk("stopbeat_rx_cnt", rx_cnt, 32'd0);
        chk("stopbeat_stat", stat, 32'h0);
        chk("stopbeat_tready", 32'(tready), 32'h0);

        // num_pkts = 0: done immediately, nothing accepted.
        setup(0, 16, 0);
        tvalid = 1'b1;
        tdata  = 32'd0;
        tlast  = 1'b1;
        seen   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tready) seen = 1'b1;
        end
        tvalid = 1'b0;
        chk("np0_accepted", 32'(seen), 32'h0);
        chk("np0_stat", stat, 32'h2);
        chk("np0_pkts", rx_pkt_cnt, 32'd0);

        // Asynchronous reset between edges.
        setup(0, 16, 2);
        send(32'd0, 1'b0, 4'hF);
        send(32'd1, 1'b0, 4'hF);
        tdata = 32'd2;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tready", 32'(tready), 32'h0);
        chk("arst_stat", stat, 32'h0);
        chk("arst_rx_cnt", rx_cnt, 32'h0);
        chk("arst_err", err_cnt, 32'h0);
        tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Randomized packets against the reference model.
        for (int it = 0; it < 4; it++) begin
            setup(int'($urandom_range(0, 1)), NB * int'($urandom_range(2, 4)), 6);
            src = 32'h0;
            for (int p = 0; p < 6; p++) begin
                k = m_nb / NB;
                case ($urandom_range(0, 7))
                    0:       k = k - 1;
                    1:       k = k + 1;
                    default: k = k;
                endcase
                for (int b = 0; b < k; b++) begin
                    d = src;
                    s = 4'hF;
                    if ($urandom_range(0, 9) == 0) d = $urandom;
                    if ($urandom_range(0, 19) == 0) s = 4'h7;
                    if ($urandom_range(0, 3) == 0) begin
                        tvalid = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    send(d, b == k - 1, s);
                    src = (m_dtype == 1) ? src - 32'd1 : src + 32'd1;
                end
                tvalid = 1'b0;
                chk($sformatf("r%0d_%0d_pkts", it, p), rx_pkt_cnt, 32'(m_pkts));
                chk($sformatf("r%0d_%0d_err", it, p), err_cnt, 32'(m_err));
                chk($sformatf("r%0d_%0d_lerr", it, p), tlast_err_cnt, 32'(m_lerr));
                chk($sformatf("r%0d_%0d_first", it, p), first_err_data, m_first);
                chk($sformatf("r%0d_%0d_rx_cnt", it, p), rx_cnt, 32'h0);
                chk($sformatf("r%0d_%0d_stat", it, p), stat, m_stat());
            end
            chk($sformatf("r%0d_tready", it), 32'(tready), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
